// File: rtl/serial_magnitude_comparator_if.sv
// Start/done request bundle for the bit-serial magnitude comparator.
// The requester drives operands and start; the comparator returns status and the one-hot result.
interface serial_magnitude_comparator_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: resolves A vs B one bit per clock, LSB first,
// and registers a one-hot eq/gt/lt result with a single-cycle done pulse.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 4
) (
    input logic                          clk,
    input logic                          rst_n,
    serial_magnitude_comparator_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StRun} state_e;
    typedef enum logic [1:0] {RelEq, RelGt, RelLt} rel_e;

    state_e           state_q, state_d;
    rel_e             rel_q, rel_d, rel_step;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

    // LSB-first scan: any later (more significant) difference overrides the running relation.
    always_comb begin
        rel_step = rel_q;
        if (sa_q[0] && !sb_q[0]) begin
            rel_step = RelGt;
        end else if (!sa_q[0] && sb_q[0]) begin
            rel_step = RelLt;
        end
    end

    always_comb begin
        state_d = state_q;
        rel_d   = rel_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    cnt_d   = '0;
                    rel_d   = RelEq;
                    state_d = StRun;
                end
            end
            StRun: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                rel_d = rel_step;
                if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    eq_d    = (rel_step == RelEq);
                    gt_d    = (rel_step == RelGt);
                    lt_d    = (rel_step == RelLt);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            eq_q    <= 1'b1;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    // Datapath is only meaningful after an accept, so it carries no reset.
    always_ff @(posedge clk) begin
        sa_q  <= sa_d;
        sb_q  <= sb_d;
        cnt_q <= cnt_d;
        rel_q <= rel_d;
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = done_q;
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator at WIDTH=4 and WIDTH=16.
// Drivers push expected {eq,gt,lt} and done cycle; per-DUT monitors pop on done.
module tb_serial_magnitude_comparator;
    localparam int unsigned W4  = 4;
    localparam int unsigned W16 = 16;
    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_magnitude_comparator_if #(.WIDTH(W4))  if4 ();
    serial_magnitude_comparator_if #(.WIDTH(W16)) if16 ();

    serial_magnitude_comparator #(.WIDTH(W4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    serial_magnitude_comparator #(.WIDTH(W16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    typedef struct {
        int         cyc;
        logic [2:0] res;
    } exp_t;

    exp_t q4[$];
    exp_t q16[$];
    exp_t e4, e16;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_done4 = 1'b0;
    logic prev_done16 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [2:0] cmp(input logic [15:0] x, input logic [15:0] y);
        if (x == y) return EQ;
        if (x > y) return GT;
        return LT;
    endfunction

    always @(negedge clk) begin
        check("onehot4", 32'($countones({if4.eq, if4.gt, if4.lt})), 1);
        check("done_busy4", {31'd0, if4.done & if4.busy}, 0);
        check("done_twice4", {31'd0, if4.done & prev_done4}, 0);
        prev_done4 = if4.done;
        if (if4.done) begin
            if (q4.size() == 0) begin
                check("unexpected_done4", 1, 0);
            end else begin
                e4 = q4.pop_front();
                check("latency4", cyc, e4.cyc);
                check("result4", {29'd0, if4.eq, if4.gt, if4.lt}, {29'd0, e4.res});
            end
        end
    end

    always @(negedge clk) begin
        check("onehot16", 32'($countones({if16.eq, if16.gt, if16.lt})), 1);
        check("done_busy16", {31'd0, if16.done & if16.busy}, 0);
        check("done_twice16", {31'd0, if16.done & prev_done16}, 0);
        prev_done16 = if16.done;
        if (if16.done) begin
            if (q16.size() == 0) begin
                check("unexpected_done16", 1, 0);
            end else begin
                e16 = q16.pop_front();
                check("latency16", cyc, e16.cyc);
                check("result16", {29'd0, if16.eq, if16.gt, if16.lt}, {29'd0, e16.res});
            end
        end
    end

    // Returns one ns after the accepting edge; operands are scrambled to prove they were latched.
    task automatic issue4(input logic [3:0] x, input logic [3:0] y, input bit push,
                          input logic [2:0] res);
        if4.start = 1'b1;
        if4.a     = x;
        if4.b     = y;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        if4.a     = ~x;
        if4.b     = 4'($urandom);
        if (push) q4.push_back('{cyc + int'(W4), res});
    endtask

    task automatic issue16(input logic [15:0] x, input logic [15:0] y);
        if16.start = 1'b1;
        if16.a     = x;
        if16.b     = y;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        if16.a     = ~x;
        if16.b     = 16'($urandom);
        q16.push_back('{cyc + int'(W16), cmp(x, y)});
    endtask

    // Advances into the done cycle so the next issue is back-to-back.
    task automatic settle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] dx [8] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001, 16'h1234, 16'hFFFE,
                            16'h7FFF, 16'hA5A5};
    logic [15:0] dy [8] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF,
                            16'hFFFF, 16'hA5A4};

    initial begin
        if4.start  = 1'b0;
        if4.a      = '0;
        if4.b      = '0;
        if16.start = 1'b0;
        if16.a     = '0;
        if16.b     = '0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", {31'd0, if4.busy}, 0);
        check("rst_done", {31'd0, if4.done}, 0);
        check("rst_result", {29'd0, if4.eq, if4.gt, if4.lt}, {29'd0, EQ});
        check("rst_result16", {29'd0, if16.eq, if16.gt, if16.lt}, {29'd0, EQ});
        settle(20);

        issue4(4'd9, 4'd6, 1, GT);   settle(W4);
        issue4(4'd3, 4'd12, 1, LT);  settle(W4);
        issue4(4'd10, 4'd10, 1, EQ); settle(W4);
        issue4(4'b1000, 4'b0111, 1, GT); settle(W4);
        issue4(4'd0, 4'd15, 1, LT);  settle(W4);
        issue4(4'd15, 4'd15, 1, EQ); settle(W4);
        issue4(4'b0001, 4'b1110, 1, LT); settle(W4);

        // Start pulsed while busy must be dropped.
        issue4(4'd10, 4'd3, 1, GT);
        @(posedge clk);
        #1;
        if4.start = 1'b1;
        if4.a     = 4'd0;
        if4.b     = 4'd15;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        settle(2);
        // Issued inside the done cycle: second done lands WIDTH+1 cycles after the first.
        issue4(4'd2, 4'd5, 1, LT);
        settle(W4 + 3);

        // Reset on the second RUN edge aborts with no done.
        issue4(4'd9, 4'd6, 0, EQ);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, if4.busy}, 0);
        check("midrst_done", {31'd0, if4.done}, 0);
        check("midrst_result", {29'd0, if4.eq, if4.gt, if4.lt}, {29'd0, EQ});
        settle(8);
        issue4(4'd1, 4'd2, 1, LT);
        settle(W4);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                issue4(4'(i), 4'(j), 1, cmp(16'(i), 16'(j)));
                settle(W4);
            end
        end

        for (int k = 0; k < 8; k++) begin
            issue16(dx[k], dy[k]);
            settle(W16);
        end
        for (int k = 0; k < 200; k++) begin
            issue16(16'($urandom), 16'($urandom));
            settle(W16);
        end

        settle(W16 + 4);
        check("drain4", q4.size(), 0);
        check("drain16", q16.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
